// File: rtl/regfile_write_demux_if.sv
// regfile_write_demux_if: issue, writeback, hazard-query and register-file write bundle
// for the write demux. Revision 1.0.
`default_nettype none

interface regfile_write_demux_if #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter int ADDR_W = $clog2(NREG)
);
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_stall;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [NREG-1:0]   wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              sb_err;

  modport master (
    output issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush, rs1_addr, rs2_addr,
    input  issue_stall, rs1_pending, rs2_pending, wr_en, wr_data, sb_err
  );

  modport slave (
    input  issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush, rs1_addr, rs2_addr,
    output issue_stall, rs1_pending, rs2_pending, wr_en, wr_data, sb_err
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_demux.sv
// regfile_write_demux: registered one-hot WB write fan-out plus per-register in-flight
// writer scoreboard for RAW hazard detection. Revision 1.0.
`default_nettype none

module regfile_write_demux #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 32,
  parameter int ADDR_W   = $clog2(NREG),
  parameter int ZERO_REG = 31,
  parameter int MAX_INFL = 3
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  regfile_write_demux_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_INFL + 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = CNT_W'(MAX_INFL);
  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);
  localparam logic [1:0]        c_tail_len  = 2'd2;

  logic [NREG-1:0][CNT_W-1:0] w_cnt;
  logic                       w_wb_hit;
  logic                       w_issue_ok;
  logic                       w_issue_full;
  logic                       w_underflow;
  logic [NREG-1:0]            r_wr_en;
  logic [DATA_W-1:0]          r_wr_data;
  logic                       r_sb_err;
  logic [1:0]                 r_flush_tail;

  // Out-of-range addresses behave exactly like the zero register.
  assign w_wb_hit   = bus.wb_valid && (int'(bus.wb_addr) < NREG) && (bus.wb_addr != c_zero_addr);
  assign w_issue_ok = bus.issue_valid && (int'(bus.issue_addr) < NREG)
                      && (bus.issue_addr != c_zero_addr);

  assign w_issue_full = w_issue_ok && (w_cnt[bus.issue_addr] == c_cnt_max)
                        && !(bus.wb_valid && bus.wb_addr == bus.issue_addr);
  assign bus.issue_stall = w_issue_full;

  assign bus.rs1_pending = (int'(bus.rs1_addr) < NREG) && (w_cnt[bus.rs1_addr] != '0);
  assign bus.rs2_pending = (int'(bus.rs2_addr) < NREG) && (w_cnt[bus.rs2_addr] != '0);

  assign w_underflow = w_wb_hit && (w_cnt[bus.wb_addr] == '0);

  genvar r;
  generate
    for (r = 0; r < NREG; r++) begin : g_cnt
      if (r == ZERO_REG) begin : g_zero
        assign w_cnt[r] = '0;
      end else begin : g_live
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_issue_ok && !w_issue_full && (bus.issue_addr == ADDR_W'(r));
        assign w_dec = w_wb_hit && (bus.wb_addr == ADDR_W'(r)) && (r_cnt != '0);

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= '0;
          end else if (bus.flush) begin
            r_cnt <= '0;
          end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (w_dec && !w_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        assign w_cnt[r] = r_cnt;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else if (w_wb_hit) begin
      r_wr_en   <= NREG'(1) << bus.wb_addr;
      r_wr_data <= bus.wb_data;
    end else begin
      r_wr_en   <= '0;
    end
  end

  // Writers discarded by a flush may still retire during the flush and the two cycles
  // after it, so their zero-count writes are not treated as scoreboard errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_tail <= '0;
      r_sb_err     <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_flush_tail <= c_tail_len;
      end else if (r_flush_tail != '0) begin
        r_flush_tail <= r_flush_tail - 2'd1;
      end
      if (w_underflow && !bus.flush && (r_flush_tail == '0)) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_data = r_wr_data;
  assign bus.sb_err  = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_demux.sv
// tb_regfile_write_demux: directed scenarios plus randomized traffic checked against an
// array-based scoreboard model. Revision 1.0.
`default_nettype none

module tb_regfile_write_demux;

  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int ZREG   = 31;
  localparam int MAXI   = 3;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  int               m_cnt [NREG];
  bit               m_err;
  int               m_tail;
  logic [NREG-1:0]  m_wr_en;
  logic [DATA_W-1:0] m_wr_data;

  regfile_write_demux_if #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) bus ();

  regfile_write_demux #(
    .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .ZERO_REG(ZREG), .MAX_INFL(MAXI)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    m_err     = 1'b0;
    m_tail    = 0;
    m_wr_en   = '0;
    m_wr_data = '0;
  endtask

  task automatic do_reset();
    idle();
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    reset_n = 1'b0;
    #7;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle with the inputs already applied: combinational outputs are checked
  // mid-cycle, registered outputs just after the edge.
  task automatic cycle();
    bit                iv, wv, fl, stall;
    logic [ADDR_W-1:0] ia, wa;
    logic [DATA_W-1:0] wd;
    int                nxt [NREG];
    @(negedge clk);
    iv = bus.issue_valid; ia = bus.issue_addr;
    wv = bus.wb_valid;    wa = bus.wb_addr;   wd = bus.wb_data;
    fl = bus.flush;
    stall = iv && (ia != ZREG) && (m_cnt[ia] == MAXI) && !(wv && wa == ia);
    chk("issue_stall", bus.issue_stall, stall);
    chk("rs1_pending", bus.rs1_pending, m_cnt[bus.rs1_addr] != 0);
    chk("rs2_pending", bus.rs2_pending, m_cnt[bus.rs2_addr] != 0);
    @(posedge clk);
    nxt = m_cnt;
    if (iv && !stall && ia != ZREG) nxt[ia] = nxt[ia] + 1;
    if (wv && wa != ZREG) begin
      if (m_cnt[wa] == 0) begin
        if (!fl && m_tail == 0) m_err = 1'b1;
      end else begin
        nxt[wa] = nxt[wa] - 1;
      end
      m_wr_en   = NREG'(1) << wa;
      m_wr_data = wd;
    end else begin
      m_wr_en = '0;
    end
    if (fl) for (int i = 0; i < NREG; i++) nxt[i] = 0;
    m_tail = fl ? 2 : (m_tail > 0 ? m_tail - 1 : 0);
    m_cnt  = nxt;
    #1;
    chk("wr_en", bus.wr_en, m_wr_en);
    chk("wr_data", bus.wr_data, m_wr_data);
    chk("sb_err", bus.sb_err, m_err);
  endtask

  task automatic issue(input int a);
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = ADDR_W'(a);
  endtask

  task automatic wb(input int a, input logic [DATA_W-1:0] d);
    bus.wb_valid = 1'b1; bus.wb_addr = ADDR_W'(a); bus.wb_data = d;
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 9) == 0) ? ZREG : int'($urandom_range(0, 7));
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle();
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    do_reset();
    chk("reset_wr_en", bus.wr_en, 32'h0);
    chk("reset_wr_data", bus.wr_data, 64'h0);
    chk("reset_sb_err", bus.sb_err, 1'b0);

    // Basic write, then hold of data
    idle(); wb(5, 64'hDEAD_BEEF); cycle();
    chk("t1_wr_en", bus.wr_en, 32'h0000_0020);
    chk("t1_wr_data", bus.wr_data, 64'hDEAD_BEEF);
    idle(); cycle();
    chk("t1_wr_en_clr", bus.wr_en, 32'h0);
    chk("t1_wr_data_hold", bus.wr_data, 64'hDEAD_BEEF);

    // Zero register write is dropped
    do_reset();
    idle(); wb(31, 64'h1234); cycle();
    chk("t2_wr_en", bus.wr_en, 32'h0);
    chk("t2_sb_err", bus.sb_err, 1'b0);

    // Saturation and same-cycle retire
    bus.rs1_addr = 5'd3;
    repeat (3) begin issue(3); cycle(); end
    #1 chk("t3_pending", bus.rs1_pending, 1'b1);
    issue(3);
    #1 chk("t3_stall", bus.issue_stall, 1'b1);
    cycle();
    issue(3); wb(3, 64'h33);
    #1 chk("t3_stall_retire", bus.issue_stall, 1'b0);
    cycle();
    issue(3);
    #1 chk("t3_still_full", bus.issue_stall, 1'b1);
    cycle();

    // Underflow sets sticky error, write still happens
    do_reset();
    bus.rs1_addr = 5'd7;
    issue(7); cycle();
    idle(); wb(7, 64'h71); cycle();
    #1 chk("t4_pending_clr", bus.rs1_pending, 1'b0);
    idle(); wb(7, 64'h72); cycle();
    chk("t4_sb_err", bus.sb_err, 1'b1);
    chk("t4_wr_en", bus.wr_en, 32'h0000_0080);
    idle(); cycle();
    chk("t4_sticky", bus.sb_err, 1'b1);

    // Flush with same-cycle WB, then late WB inside the tail window
    do_reset();
    issue(1); cycle();
    issue(2); cycle();
    issue(4); cycle();
    idle(); bus.flush = 1'b1; wb(9, 64'h99); cycle();
    chk("t5_wr_en", bus.wr_en, 32'h0000_0200);
    bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd4;
    idle(); wb(1, 64'h11); cycle();
    chk("t5_sb_err", bus.sb_err, 1'b0);

    // Asynchronous reset mid-cycle
    do_reset();
    bus.rs1_addr = 5'd6;
    issue(6); cycle();
    issue(6); cycle();
    idle(); wb(5, 64'h55); cycle();
    chk("t6_pre_wr_en", bus.wr_en, 32'h0000_0020);
    chk("t6_pre_err", bus.sb_err, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_wr_en", bus.wr_en, 32'h0);
    chk("t6_sb_err", bus.sb_err, 1'b0);
    chk("t6_pending", bus.rs1_pending, 1'b0);
    do_reset();

    // Randomized traffic in segments so the sticky error is re-armed
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        idle();
        bus.issue_valid = ($urandom_range(0, 9) < 6);
        bus.issue_addr  = ADDR_W'(pick_addr());
        bus.wb_valid    = ($urandom_range(0, 9) < 4);
        bus.wb_addr     = ADDR_W'(pick_addr());
        bus.wb_data     = {$urandom, $urandom};
        bus.flush       = ($urandom_range(0, 39) == 0);
        bus.rs1_addr    = ADDR_W'(pick_addr());
        bus.rs2_addr    = ADDR_W'(pick_addr());
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
